// File: rtl/a_to_five_pkg.sv
// Shared definitions for the A-header serial link (transmitter and receiver).
// Header nibbles, frame width and the transmit FSM state encoding.
package a_to_five_pkg;

   localparam logic [3:0]  HEADER_A = 4'b1010;
   localparam logic [3:0]  HEADER_5 = 4'b0101;
   localparam int unsigned FRAME_W  = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/a_to_five_shifter.sv
// Loadable parallel-in/serial-out shift register, MSB first.
// A load with shift_en set consumes the first bit in the same cycle.
module a_to_five_shifter
   import a_to_five_pkg::*;
#(
   parameter int unsigned W = FRAME_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_shift_en,
   input  logic [W-1:0] i_d,
   output logic         o_msb
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_shift_en ? {i_d[W-2:0], 1'b0} : i_d;
      end else if (i_shift_en) begin
         r_q <= {r_q[W-2:0], 1'b0};
      end
   end

   assign o_msb = r_q[W-1];

endmodule

// File: rtl/a_to_five_tx.sv
// A-header frame transmitter: takes a payload on valid/ready, prepends HEADER
// and shifts the frame out MSB first, one bit per enabled clock.
module a_to_five_tx
   import a_to_five_pkg::*;
#(
   parameter logic [3:0]  HEADER = HEADER_A,
   parameter int unsigned DATA_W = FRAME_W - 4,
   parameter int unsigned GAP    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              tx_en,
   output logic              out,
   output logic              out_valid,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned FRAME_BITS = 4 + DATA_W;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
   localparam int unsigned GAP_W      = 4;

   tx_state_t                r_state, w_next;
   logic [CNT_W-1:0]         r_bit_cnt, w_bit_nxt;
   logic [GAP_W-1:0]         r_gap_cnt, w_gap_nxt;
   logic                     r_out, r_out_valid, r_busy;
   logic [15:0]              r_frame_cnt;
   logic [FRAME_BITS-1:0]    w_frame;
   logic                     w_msb, w_last, w_ready, w_hs;
   logic                     w_load, w_shift, w_out_nxt, w_valid_nxt, w_done;

   assign w_frame = {HEADER, in_data};
   // Bit counter counts bits already emitted; all emitted means the last bit is on out.
   assign w_last  = (r_bit_cnt == CNT_W'(FRAME_BITS));
   assign w_ready = !rst && ((r_state == ST_IDLE) ||
                             ((r_state == ST_SEND) && w_last && (GAP == 0)));
   assign w_hs    = in_valid && w_ready;

   a_to_five_shifter #(.W(FRAME_BITS)) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_shift_en (w_shift),
      .i_d        (w_frame),
      .o_msb      (w_msb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_out_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      w_bit_nxt   = r_bit_cnt;
      w_gap_nxt   = r_gap_cnt;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: w_load = w_hs;
         ST_SEND: begin
            if (w_last) begin
               w_done    = 1'b1;
               w_bit_nxt = '0;
               if (GAP != 0) begin
                  w_next    = ST_GAP;
                  w_gap_nxt = GAP_W'(GAP);
               end else if (w_hs) begin
                  w_load = 1'b1;
               end else begin
                  w_next = ST_IDLE;
               end
            end else if (tx_en) begin
               w_shift     = 1'b1;
               w_out_nxt   = w_msb;
               w_valid_nxt = 1'b1;
               w_bit_nxt   = r_bit_cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (r_gap_cnt <= GAP_W'(1)) begin
               w_next    = ST_IDLE;
               w_gap_nxt = '0;
            end else begin
               w_gap_nxt = r_gap_cnt - GAP_W'(1);
            end
         end
         default: w_next = ST_IDLE;
      endcase
      // The load cycle already emits the header MSB so the first bit lands one cycle later.
      if (w_load) begin
         w_next      = ST_SEND;
         w_shift     = tx_en;
         w_out_nxt   = tx_en & w_frame[FRAME_BITS-1];
         w_valid_nxt = tx_en;
         w_bit_nxt   = tx_en ? CNT_W'(1) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_out       <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_bit_cnt   <= w_bit_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_out       <= w_out_nxt;
         r_out_valid <= w_valid_nxt;
         r_busy      <= (w_next != ST_IDLE);
         if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign in_ready  = w_ready;
   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_a_to_five_tx.sv
// Directed bench for a_to_five_tx: one instance with GAP=0, one with GAP=3.
module tb_a_to_five_tx;
   import a_to_five_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_en = 1'b0;
   logic        iv0 = 1'b0;
   logic        iv3 = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        ir0, ir3, o0, o3, ov0, ov3, b0, b3;
   logic [15:0] fc0, fc3;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   a_to_five_tx #(.HEADER(HEADER_A), .DATA_W(8), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv0), .in_ready(ir0),
      .tx_en(tx_en), .out(o0), .out_valid(ov0), .busy(b0), .frame_cnt(fc0)
   );

   a_to_five_tx #(.HEADER(HEADER_A), .DATA_W(8), .GAP(3)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv3), .in_ready(ir3),
      .tx_en(tx_en), .out(o3), .out_valid(ov3), .busy(b3), .frame_cnt(fc3)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full frame on dut0 with tx_en high, called at a negedge while dut0 is idle.
   task automatic send0(input logic [7:0] d, input logic [15:0] exp_cnt);
      logic [11:0] f;
      f = {HEADER_A, d};
      chk("s_idle_ready", 16'(ir0), 16'd1);
      iv0 = 1'b1; in_data = d; tx_en = 1'b1;
      @(negedge clk);
      iv0 = 1'b0; in_data = ~d;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("s_valid%0d", i), 16'(ov0), 16'd1);
         chk($sformatf("s_bit%0d", i), 16'(o0), 16'(f[11-i]));
         chk($sformatf("s_ready%0d", i), 16'(ir0), 16'(i == 11));
         chk($sformatf("s_busy%0d", i), 16'(b0), 16'd1);
         @(negedge clk);
      end
      chk("s_post_valid", 16'(ov0), 16'd0);
      chk("s_post_busy", 16'(b0), 16'd0);
      chk("s_frame_cnt", fc0, exp_cnt);
   endtask

   initial begin
      logic [23:0] s;
      logic [11:0] f;
      int          k;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 16'(ir0), 16'd0);
      chk("rst_valid", 16'(ov0), 16'd0);
      chk("rst_out", 16'(o0), 16'd0);
      chk("rst_busy", 16'(b0), 16'd0);
      chk("rst_cnt", fc0, 16'd0);
      rst = 1'b0;
      #1;
      chk("rel_ready", 16'(ir0), 16'd1);
      @(negedge clk);

      // single frame 8'h3C
      send0(8'h3C, 16'd1);

      // back-to-back 8'hFF then 8'h00, continuous 24-bit stream
      s = {HEADER_A, 8'hFF, HEADER_A, 8'h00};
      chk("b2b_ready0", 16'(ir0), 16'd1);
      in_data = 8'hFF; iv0 = 1'b1;
      @(negedge clk);
      in_data = 8'h00;
      for (int i = 0; i < 24; i++) begin
         chk($sformatf("b2b_valid%0d", i), 16'(ov0), 16'd1);
         chk($sformatf("b2b_bit%0d", i), 16'(o0), 16'(s[23-i]));
         chk($sformatf("b2b_ready%0d", i), 16'(ir0), 16'((i == 11) || (i == 23)));
         if (i == 12) iv0 = 1'b0;
         @(negedge clk);
      end
      chk("b2b_post_valid", 16'(ov0), 16'd0);
      chk("b2b_cnt", fc0, 16'd3);

      // GAP=3 instance, two payloads with in_valid held
      f = {HEADER_A, 8'h5A};
      chk("gap_ready0", 16'(ir3), 16'd1);
      in_data = 8'h5A; iv3 = 1'b1;
      @(negedge clk);
      in_data = 8'hC3;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("g1_valid%0d", i), 16'(ov3), 16'd1);
         chk($sformatf("g1_bit%0d", i), 16'(o3), 16'(f[11-i]));
         chk($sformatf("g1_ready%0d", i), 16'(ir3), 16'd0);
         @(negedge clk);
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("gap_valid%0d", g), 16'(ov3), 16'd0);
         chk($sformatf("gap_ready%0d", g), 16'(ir3), 16'd0);
         chk($sformatf("gap_busy%0d", g), 16'(b3), 16'd1);
         @(negedge clk);
      end
      chk("gap_idle_ready", 16'(ir3), 16'd1);
      chk("gap_idle_busy", 16'(b3), 16'd0);
      chk("gap_cnt1", fc3, 16'd1);
      @(negedge clk);
      iv3 = 1'b0;
      f = {HEADER_A, 8'hC3};
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("g2_valid%0d", i), 16'(ov3), 16'd1);
         chk($sformatf("g2_bit%0d", i), 16'(o3), 16'(f[11-i]));
         @(negedge clk);
      end
      chk("gap_post_valid", 16'(ov3), 16'd0);
      chk("gap_cnt2", fc3, 16'd2);

      // tx_en low for two cycles after bit 5 of 8'hA5
      f = {HEADER_A, 8'hA5};
      k = 0;
      chk("stall_ready0", 16'(ir0), 16'd1);
      in_data = 8'hA5; iv0 = 1'b1; tx_en = 1'b1;
      @(negedge clk);
      iv0 = 1'b0;
      for (int c = 0; c < 14; c++) begin
         chk($sformatf("st_valid%0d", c), 16'(ov0), 16'(!((c == 5) || (c == 6))));
         if (!((c == 5) || (c == 6))) begin
            chk($sformatf("st_bit%0d", k), 16'(o0), 16'(f[11-k]));
            k++;
         end
         tx_en = !((c == 4) || (c == 5));
         @(negedge clk);
      end
      chk("st_post_valid", 16'(ov0), 16'd0);
      chk("st_cnt", fc0, 16'd4);

      // asynchronous reset after bit 6, then a clean frame 8'h81
      f = {HEADER_A, 8'hFF};
      in_data = 8'hFF; iv0 = 1'b1;
      @(negedge clk);
      iv0 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("pr_bit%0d", c), 16'(o0), 16'(f[11-c]));
         @(negedge clk);
      end
      chk("pr_valid_before", 16'(ov0), 16'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 16'(ov0), 16'd0);
      chk("ar_out", 16'(o0), 16'd0);
      chk("ar_busy", 16'(b0), 16'd0);
      chk("ar_ready", 16'(ir0), 16'd0);
      chk("ar_cnt", fc0, 16'd0);
      chk("ar_cnt3", fc3, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ar_rel_ready", 16'(ir0), 16'd1);
      chk("ar_rel_valid", 16'(ov0), 16'd0);
      send0(8'h81, 16'd1);

      // frame_cnt wrap from 16'hFFFF
      force dut0.r_frame_cnt = 16'hFFFF;
      #1;
      release dut0.r_frame_cnt;
      chk("wrap_pre", fc0, 16'hFFFF);
      send0(8'h3C, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
